// File: rtl/countdown_timer_if.sv
// Bus bundle for the countdown timer: start/stop and load controls, the BCD
// preset digits, and the registered BCD count plus status flags.
interface countdown_timer_if;
   logic       start_stop;
   logic       load;
   logic [3:0] preset_m10;
   logic [3:0] preset_m1;
   logic [3:0] preset_s10;
   logic [3:0] preset_s1;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       expired;
   logic       done_pulse;

   modport master (
      output start_stop, load, preset_m10, preset_m1, preset_s10, preset_s1,
      input  min_tens, min_ones, sec_tens, sec_ones, running, expired, done_pulse
   );

   modport slave (
      input  start_stop, load, preset_m10, preset_m1, preset_s10, preset_s1,
      output min_tens, min_ones, sec_tens, sec_ones, running, expired, done_pulse
   );
endinterface

// File: rtl/countdown_timer.sv
// Down-counting mm:ss timer. One shared prescaler produces a once-per-second
// tick that drives a BCD borrow chain across the four digits. Expiry at 00:00
// parks the block in DONE until a new preset is loaded.
module countdown_timer #(
   parameter int TICK_DIV = 50000000
) (
   input logic clock,
   input logic reset,
   countdown_timer_if.slave bus
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t state;
   state_t state_next;

   logic          prev_ss;
   logic          ss_edge;
   logic          load_ok;
   logic          tick;
   logic          count_zero;
   logic          last_second;
   logic [PW-1:0] prescaler;
   logic [PW-1:0] prescaler_next;
   logic [3:0]    m10, m1, s10, s1;
   logic [3:0]    m10_next, m1_next, s10_next, s1_next;
   logic          running_q, expired_q, done_q;
   logic          done_next;

   assign ss_edge     = bus.start_stop & ~prev_ss;
   assign load_ok     = bus.load && (state != RUN);
   assign tick        = (state == RUN) && !ss_edge && (prescaler == LAST);
   assign count_zero  = (m10 == 4'd0) && (m1 == 4'd0) && (s10 == 4'd0) && (s1 == 4'd0);
   assign last_second = (m10 == 4'd0) && (m1 == 4'd0) && (s10 == 4'd0) && (s1 == 4'd1);

   assign bus.min_tens   = m10;
   assign bus.min_ones   = m1;
   assign bus.sec_tens   = s10;
   assign bus.sec_ones   = s1;
   assign bus.running    = running_q;
   assign bus.expired    = expired_q;
   assign bus.done_pulse = done_q;

   // State register; the edge detector lives alongside it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         prev_ss <= 1'b0;
      end else begin
         state   <= state_next;
         prev_ss <= bus.start_stop;
      end
   end

   // Next-state decision; a permitted load always beats a start/stop edge.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (load_ok)                    state_next = IDLE;
            else if (ss_edge && !count_zero) state_next = RUN;
         end
         RUN: begin
            if (ss_edge)                    state_next = PAUSE;
            else if (tick && last_second)   state_next = DONE;
         end
         PAUSE: begin
            if (load_ok)                    state_next = IDLE;
            else if (ss_edge)               state_next = RUN;
         end
         DONE: begin
            if (load_ok)                    state_next = IDLE;
         end
         default:                           state_next = IDLE;
      endcase
   end

   // Datapath: clamped preset load, prescaler advance, and the digit borrow chain.
   always_comb begin
      prescaler_next = prescaler;
      m10_next       = m10;
      m1_next        = m1;
      s10_next       = s10;
      s1_next        = s1;
      done_next      = tick && last_second;

      if (load_ok || state == IDLE) begin
         prescaler_next = '0;
      end else if (state == RUN && !ss_edge) begin
         prescaler_next = tick ? '0 : prescaler + 1'b1;
      end

      if (load_ok) begin
         m10_next = (bus.preset_m10 > 4'd5) ? 4'd5 : bus.preset_m10;
         m1_next  = (bus.preset_m1  > 4'd9) ? 4'd9 : bus.preset_m1;
         s10_next = (bus.preset_s10 > 4'd5) ? 4'd5 : bus.preset_s10;
         s1_next  = (bus.preset_s1  > 4'd9) ? 4'd9 : bus.preset_s1;
      end else if (tick) begin
         if (s1 != 4'd0) begin
            s1_next = s1 - 4'd1;
         end else begin
            s1_next = 4'd9;
            if (s10 != 4'd0) begin
               s10_next = s10 - 4'd1;
            end else begin
               s10_next = 4'd5;
               if (m1 != 4'd0) begin
                  m1_next = m1 - 4'd1;
               end else begin
                  m1_next  = 4'd9;
                  m10_next = m10 - 4'd1;
               end
            end
         end
      end
   end

   // Datapath and output registers; status flags follow the post-edge state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         m10       <= 4'd0;
         m1        <= 4'd0;
         s10       <= 4'd0;
         s1        <= 4'd0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         prescaler <= prescaler_next;
         m10       <= m10_next;
         m1        <= m1_next;
         s10       <= s10_next;
         s1        <= s1_next;
         running_q <= (state_next == RUN);
         expired_q <= (state_next == DONE);
         done_q    <= done_next;
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios followed by random traffic,
// all compared each cycle against a seconds-based reference model.
module tb_countdown_timer;

   localparam int TICK_DIV = 4;
   localparam int MODE_IDLE  = 0;
   localparam int MODE_RUN   = 1;
   localparam int MODE_PAUSE = 2;
   localparam int MODE_DONE  = 3;

   logic clock;
   logic reset;
   countdown_timer_if bus_if ();

   countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int check_count = 0;
   int pass_count  = 0;

   int   m_secs;
   int   m_mode;
   int   m_frac;
   logic m_prev;
   logic m_done;

   logic [3:0] cur_p [4];

   task automatic resetModel();
      m_secs = 0;
      m_mode = MODE_IDLE;
      m_frac = 0;
      m_prev = 1'b0;
      m_done = 1'b0;
   endtask

   function automatic int clampDigit(input logic [3:0] d, input int lim);
      return (int'(d) > lim) ? lim : int'(d);
   endfunction

   task automatic modelStep(input logic ss, input logic ld,
                            input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
      logic edge_seen;
      edge_seen = ss & ~m_prev;
      m_prev = ss;
      m_done = 1'b0;
      if (ld && m_mode != MODE_RUN) begin
         m_secs = clampDigit(a, 5) * 600 + clampDigit(b, 9) * 60 +
                  clampDigit(c, 5) * 10 + clampDigit(d, 9);
         m_frac = 0;
         m_mode = MODE_IDLE;
      end else begin
         case (m_mode)
            MODE_IDLE: if (edge_seen && m_secs != 0) begin
               m_mode = MODE_RUN;
               m_frac = 0;
            end
            MODE_RUN: begin
               if (edge_seen) m_mode = MODE_PAUSE;
               else if (m_frac == TICK_DIV - 1) begin
                  m_frac = 0;
                  m_secs = m_secs - 1;
                  if (m_secs == 0) begin
                     m_mode = MODE_DONE;
                     m_done = 1'b1;
                  end
               end else m_frac = m_frac + 1;
            end
            MODE_PAUSE: if (edge_seen) m_mode = MODE_RUN;
            default: ;
         endcase
      end
   endtask

   // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
   task automatic applyStimulus(input logic ss, input logic ld,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d);
      bus_if.start_stop = ss;
      bus_if.load       = ld;
      bus_if.preset_m10 = a;
      bus_if.preset_m1  = b;
      bus_if.preset_s10 = c;
      bus_if.preset_s1  = d;
      @(posedge clock);
      modelStep(ss, ld, a, b, c, d);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic [15:0] obs_d;
      logic [15:0] exp_d;
      obs_d = {bus_if.min_tens, bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones};
      exp_d = {4'(m_secs / 600), 4'((m_secs / 60) % 10), 4'((m_secs % 60) / 10), 4'(m_secs % 10)};
      check_count++;
      assert (obs_d === exp_d) pass_count++;
      else $error("[TB] FAIL %s digits: got %h expected %h", tag, obs_d, exp_d);
      check_count++;
      assert (bus_if.running === (m_mode == MODE_RUN)) pass_count++;
      else $error("[TB] FAIL %s running: got %b expected %b", tag, bus_if.running, m_mode == MODE_RUN);
      check_count++;
      assert (bus_if.expired === (m_mode == MODE_DONE)) pass_count++;
      else $error("[TB] FAIL %s expired: got %b expected %b", tag, bus_if.expired, m_mode == MODE_DONE);
      check_count++;
      assert (bus_if.done_pulse === m_done) pass_count++;
      else $error("[TB] FAIL %s done_pulse: got %b expected %b", tag, bus_if.done_pulse, m_done);
   endtask

   task automatic runCycles(input int n, input logic ss, input string tag);
      for (int i = 0; i < n; i++) begin
         applyStimulus(ss, 1'b0, cur_p[0], cur_p[1], cur_p[2], cur_p[3]);
         checkOutput(tag);
      end
   endtask

   task automatic loadPreset(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d,
                             input logic ss, input string tag);
      cur_p[0] = a; cur_p[1] = b; cur_p[2] = c; cur_p[3] = d;
      applyStimulus(ss, 1'b1, a, b, c, d);
      checkOutput(tag);
   endtask

   initial begin
      logic       rnd_ss;
      logic       rnd_ld;
      logic [3:0] rp [4];

      reset = 1'b0;
      cur_p[0] = 4'd0; cur_p[1] = 4'd0; cur_p[2] = 4'd0; cur_p[3] = 4'd0;
      bus_if.start_stop = 1'b0;
      bus_if.load       = 1'b0;
      bus_if.preset_m10 = 4'd0;
      bus_if.preset_m1  = 4'd0;
      bus_if.preset_s10 = 4'd0;
      bus_if.preset_s1  = 4'd0;
      resetModel();

      #1 reset = 1'b1;
      #1 checkOutput("reset");
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      checkOutput("reset_held");

      $display("[TB] load and borrow chain");
      loadPreset(4'd0, 4'd1, 4'd0, 4'd5, 1'b0, "load_0105");
      runCycles(1, 1'b1, "start");
      runCycles(29, 1'b1, "borrow");
      applyStimulus(1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 4'd3);
      checkOutput("load_in_run");
      runCycles(2, 1'b1, "run_on");

      $display("[TB] pause and resume");
      runCycles(1, 1'b0, "pause_prep");
      runCycles(1, 1'b1, "pause");
      runCycles(10, 1'b1, "paused_held");
      runCycles(1, 1'b0, "resume_prep");
      runCycles(1, 1'b1, "resume");
      runCycles(6, 1'b1, "resumed");
      runCycles(1, 1'b0, "pause2_prep");
      runCycles(1, 1'b1, "pause2");

      $display("[TB] expiry");
      loadPreset(4'd0, 4'd0, 4'd0, 4'd2, 1'b0, "load_0002");
      runCycles(1, 1'b1, "start2");
      runCycles(12, 1'b1, "expire");
      runCycles(1, 1'b0, "done_prep");
      runCycles(1, 1'b1, "done_edge");
      runCycles(3, 1'b0, "done_hold");
      loadPreset(4'd0, 4'd0, 4'd0, 4'd3, 1'b0, "load_after_done");

      $display("[TB] ten minute boundary");
      loadPreset(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, "load_1000");
      runCycles(1, 1'b1, "start3");
      runCycles(5, 1'b1, "ten_min");
      runCycles(1, 1'b0, "pause3_prep");
      runCycles(1, 1'b1, "pause3");

      $display("[TB] clamp and zero start");
      loadPreset(4'd7, 4'd15, 4'd6, 4'd10, 1'b0, "clamp");
      loadPreset(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "load_zero");
      runCycles(1, 1'b1, "zero_start");
      runCycles(4, 1'b1, "zero_hold");

      $display("[TB] load beats start edge");
      runCycles(1, 1'b0, "le_prep");
      loadPreset(4'd0, 4'd0, 4'd1, 4'd2, 1'b1, "load_and_edge");
      runCycles(3, 1'b1, "le_hold");

      $display("[TB] asynchronous reset mid-run");
      runCycles(1, 1'b0, "ar_prep");
      runCycles(6, 1'b1, "ar_run");
      #1 reset = 1'b1;
      resetModel();
      #1 checkOutput("async_reset");
      #1 reset = 1'b0;
      runCycles(2, 1'b1, "after_reset");

      $display("[TB] random traffic");
      rnd_ss = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) rnd_ss = ~rnd_ss;
         rnd_ld = ($urandom_range(0, 19) == 0);
         rp[0] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         rp[1] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         rp[2] = 4'($urandom_range(0, 15));
         rp[3] = 4'($urandom_range(0, 15));
         applyStimulus(rnd_ss, rnd_ld, rp[0], rp[1], rp[2], rp[3]);
         checkOutput("random");
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting mm:ss timer, the counterpart of the up-counting stopwatch in the same display design. It loads a BCD preset, then decrements once per second under start/stop control and flags expiry at 00:00. Its four BCD digit outputs feed the existing 7-segment decoders unchanged. The block replaces per-digit frequency dividers with one internal prescaler and a borrow chain.

## Interface
- TICK_DIV, 50000000, clock cycles per one-second tick (at least 2)
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE, 00:00
- start_stop  in  1  synchronous level; each rising edge (0→1 between samples) toggles run/pause
- load  in  1  synchronous, sampled every cycle; loads preset when permitted
- preset_m10, preset_m1, preset_s10, preset_s1  in  4 each  BCD preset digits
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  current count, BCD, registered
- running  out  1  high while state is RUN
- expired  out  1  high while state is DONE
- done_pulse  out  1  single-cycle pulse on entry to DONE

## Operation
- Edge detect: prev_ss register; ss_edge = start_stop & ~prev_ss; prev_ss <= start_stop every cycle.
- States: IDLE (stopped, prescaler cleared), RUN, PAUSE (stopped, prescaler fraction held), DONE.
- load is honoured in IDLE, PAUSE and DONE:
  - Digits are loaded with clamping: m10 and s10 saturate to 5; m1 and s1 saturate to 9.
  - The prescaler clears and the state goes to IDLE.
- load is ignored in RUN.
- Load and ss_edge in the same cycle: load wins (where permitted); the edge is discarded.
- IDLE + ss_edge:
  - Count nonzero: go to RUN, prescaler starts from 0.
  - Count 00:00: stay in IDLE.
- RUN + ss_edge: go to PAUSE; the prescaler value is held.
- PAUSE + ss_edge: go to RUN; the prescaler resumes from its held value.
- DONE: ss_edge is ignored. Only load or reset leaves DONE.
- Prescaler in RUN counts 0..TICK_DIV-1. The tick is asserted when it equals TICK_DIV-1, and it wraps to 0 on that same edge.
- Tick behaviour, a borrow chain:
  - s1 decrements; at 0 it wraps to 9 and borrows from s10.
  - s10 at 0 wraps to 5 and borrows from m1.
  - m1 at 0 wraps to 9 and borrows from m10.
  - m10 decrements.
- A tick that produces 00:00 moves the state to DONE on the same edge and asserts done_pulse for exactly one cycle. No underflow past 00:00 is possible.
- Prescaler width is $clog2(TICK_DIV). Digits never take non-BCD values.

## Timing
- Reset values: digits 0, running 0, expired 0, done_pulse 0, prescaler 0, prev_ss 0, state IDLE. Reset takes effect immediately (asynchronous) and overrides everything, including mid-run.
- All outputs are registered. running and expired reflect the state after the same edge that changes the state.
- Load latency: preset is visible on the digit outputs one edge after load is sampled high.
- Start latency from IDLE: with ss_edge sampled at edge k, running=1 after edge k, and the first decrement occurs at edge k+TICK_DIV.
- Pause/resume preserves elapsed fraction: if paused after p prescaler counts, the next decrement lands TICK_DIV-p RUN cycles after resume.
- Holding start_stop high produces one toggle only.
- done_pulse is high for the cycle following the terminal tick edge. expired stays high until load or reset.

## Test plan
- Load (TICK_DIV=4): preset 0,1,0,5 with load pulse → next cycle digits 01:05, running=0, expired=0.
- Borrow chain: from 01:05, start edge → 01:04 after 4 cycles; 01:00 after 20 cycles; 00:59 after 24 cycles; at 59:59-style boundary 10:00 → 09:59 on one tick.
- Expire: preset 00:02, start → 00:01 at cycle 4, 00:00 at cycle 8 with expired=1 and done_pulse high one cycle. Later start edges leave the state DONE. Load 00:03 → IDLE, expired=0.
- Pause: preset 00:09, start, pause after 2 cycles → digits hold 00:09 for 10 cycles. Resume → 00:08 exactly 2 cycles later. start_stop held high for 6 cycles toggles once only.
- Clamp/zero: preset 7,F,6,A → 59:59 loaded. Preset 00:00 plus start edge → stays IDLE, running=0, done_pulse never asserted.
- Reset/priority: asynchronous reset mid-RUN → all outputs 0 and IDLE immediately, without a clock. Load and start edge in the same IDLE cycle → preset loaded, running=0. Load during RUN → ignored, count continues.
